mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for instruction fetch and data access.
// One outstanding transaction, starvation guard for fetch, timeout abort.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic [63:0] d_rdata,
    output logic        d_valid,
    output logic        stall_if,
    output logic        stall_mem,
    err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_D = 2'd1;
    localparam logic [1:0] BUSY_I = 2'd2;

    localparam int              WW         = $clog2(TIMEOUT + 1);
    localparam logic [2:0]      STARVE_MAX = 3'(STARVE_LIMIT);
    localparam logic [WW-1:0]   WAIT_LAST  = WW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [2:0]    starve_cnt;
    logic [WW-1:0] wait_cnt;
    logic          cancel;

    logic grant_d;
    logic grant_i;
    logic busy;
    logic timeout_hit;
    logic done;
    logic cancel_now;

    // A requester still holds its line during its valid cycle, so no new
    // grant is issued while any completion pulse is on the outputs.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE && !d_valid && !if_valid) begin
            if (d_req && !(if_req && starve_cnt == STARVE_MAX)) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_i = 1'b1;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign timeout_hit = busy && !mem_rvalid && (wait_cnt == WAIT_LAST);
    assign done        = busy && (mem_rvalid || timeout_hit);
    assign cancel_now  = cancel || flush;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            wait_cnt   <= '0;
            cancel     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 64'd0;
            mem_wdata  <= 64'd0;
            if_rdata   <= 32'd0;
            if_valid   <= 1'b0;
            d_rdata    <= 64'd0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_req  <= grant_d | grant_i;
            d_valid  <= 1'b0;
            if_valid <= 1'b0;

            if (grant_d) begin
                state     <= BUSY_D;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                wait_cnt  <= '0;
            end else if (grant_i) begin
                state    <= BUSY_I;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                wait_cnt <= '0;
            end

            if (!if_req || grant_i) begin
                starve_cnt <= 3'd0;
            end else if (grant_d && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 3'd1;
            end

            if (busy) begin
                wait_cnt <= wait_cnt + WW'(1);
                if (state == BUSY_I && flush) begin
                    cancel <= 1'b1;
                end
                if (done) begin
                    state  <= IDLE;
                    cancel <= 1'b0;
                    if (timeout_hit) begin
                        err <= 1'b1;
                    end
                    if (state == BUSY_D) begin
                        d_valid <= 1'b1;
                        if (timeout_hit) begin
                            d_rdata <= 64'd0;
                        end else if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end else if (!cancel_now) begin
                        if_valid <= 1'b1;
                        if_rdata <= timeout_hit ? 32'd0 : mem_rdata[31:0];
                    end
                end
            end else if (mem_rvalid) begin
                // Stray completion with nothing outstanding.
                err <= 1'b1;
            end
        end
    end

endmodule
